// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-channel TDM demultiplexer with sync-based frame alignment
//
// Purpose: aligns to a serial 4-slot TDM stream using a slot-0 sync marker,
//          gathers one sample per slot and presents the completed frame on
//          four registered channel outputs.
// Ports:
//   clk          - sole clock, rising edge
//   reset        - asynchronous, active-high
//   enable       - slot strobe; din/sync only sampled when high
//   sync         - marks the slot-0 sample of a frame
//   din          - serial TDM data, WIDTH bits per slot
//   out0..out3   - channel data of the last complete frame (held between frames)
//   address0/1   - LSB/MSB of the next expected slot index
//   frame_valid  - one-cycle pulse: out0..out3 just updated
//   sync_err     - one-cycle pulse: sync seen at a slot index other than 0
module tdm_demux4 #(
  parameter int WIDTH         = 1,
  parameter bit RESYNC_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             address0,
  output logic             address1,
  output logic             frame_valid,
  output logic             sync_err
);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [WIDTH-1:0] sh0_q, sh0_d;
  logic [WIDTH-1:0] sh1_q, sh1_d;
  logic [WIDTH-1:0] sh2_q, sh2_d;
  logic [WIDTH-1:0] out0_q, out0_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic [WIDTH-1:0] out2_q, out2_d;
  logic [WIDTH-1:0] out3_q, out3_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      idx_q         <= 2'd0;
      sh0_q         <= '0;
      sh1_q         <= '0;
      sh2_q         <= '0;
      out0_q        <= '0;
      out1_q        <= '0;
      out2_q        <= '0;
      out3_q        <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      sh0_q         <= sh0_d;
      sh1_q         <= sh1_d;
      sh2_q         <= sh2_d;
      out0_q        <= out0_d;
      out1_q        <= out1_d;
      out2_q        <= out2_d;
      out3_q        <= out3_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    sh0_d         = sh0_q;
    sh1_d         = sh1_q;
    sh2_d         = sh2_q;
    out0_d        = out0_q;
    out1_d        = out1_q;
    out2_d        = out2_q;
    out3_d        = out3_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    if (enable) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            sh0_d   = din;
            idx_d   = 2'd1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (sync && (idx_q != 2'd0)) begin
            // Misplaced sync: the partial frame is abandoned either way; the
            // shadow slots 1..2 are simply overwritten by the next frame.
            sync_err_d = 1'b1;
            if (RESYNC_ON_ERR) begin
              sh0_d = din;
              idx_d = 2'd1;
            end else begin
              state_d = HUNT;
              idx_d   = 2'd0;
            end
          end else begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
              2'd0: sh0_d = din;
              2'd1: sh1_d = din;
              2'd2: sh2_d = din;
              default: begin
                // Slot 3 goes straight to out3 so the frame completes on this edge.
                out0_d        = sh0_q;
                out1_d        = sh1_q;
                out2_d        = sh2_q;
                out3_d        = din;
                frame_valid_d = 1'b1;
              end
            endcase
          end
        end
        default: begin
          state_d = HUNT;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  assign out0        = out0_q;
  assign out1        = out1_q;
  assign out2        = out2_q;
  assign out3        = out3_q;
  assign address0    = idx_q[0];
  assign address1    = idx_q[1];
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - scoreboard bench for tdm_demux4 (resync and hunt-on-error variants)
module tb_tdm_demux4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic sync = 1'b0;
  logic din = 1'b0;

  logic a_out0, a_out1, a_out2, a_out3, a_addr0, a_addr1, a_fv, a_se;
  logic b_out0, b_out1, b_out2, b_out3, b_addr0, b_addr1, b_fv, b_se;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       is_err;
    logic [3:0] outs;   // {out0,out1,out2,out3}
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];

  always #5 clk = ~clk;

  tdm_demux4 #(.WIDTH(1), .RESYNC_ON_ERR(1'b1)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .sync(sync), .din(din),
    .out0(a_out0), .out1(a_out1), .out2(a_out2), .out3(a_out3),
    .address0(a_addr0), .address1(a_addr1),
    .frame_valid(a_fv), .sync_err(a_se)
  );

  tdm_demux4 #(.WIDTH(1), .RESYNC_ON_ERR(1'b0)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .sync(sync), .din(din),
    .out0(b_out0), .out1(b_out1), .out2(b_out2), .out3(b_out3),
    .address0(b_addr0), .address1(b_addr1),
    .frame_valid(b_fv), .sync_err(b_se)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [3:0] o, input bit to_a, input bit to_b);
    ev_t e;
    e.is_err = 1'b0;
    e.outs   = o;
    if (to_a) qa.push_back(e);
    if (to_b) qb.push_back(e);
  endtask

  task automatic push_err(input bit to_a, input bit to_b);
    ev_t e;
    e.is_err = 1'b1;
    e.outs   = 4'h0;
    if (to_a) qa.push_back(e);
    if (to_b) qb.push_back(e);
  endtask

  // Drive one slot at the falling edge, then return just after the rising edge.
  task automatic step(input logic en, input logic s, input logic d);
    @(negedge clk);
    enable = en;
    sync   = s;
    din    = d;
    @(posedge clk);
    #1;
  endtask

  // Monitors: every frame_valid / sync_err pulse must match the next queued event.
  always @(negedge clk) begin
    if (!reset && (a_fv || a_se)) begin
      ev_t e;
      check("a_fv_se_exclusive", {6'd0, a_fv, a_se} == 8'd3 ? 8'd1 : 8'd0, 8'd0);
      if (qa.size() == 0) begin
        check("a_unexpected_event", {6'd0, a_fv, a_se}, 8'd0);
      end else begin
        e = qa.pop_front();
        check("a_event_kind", {7'd0, a_se}, {7'd0, e.is_err});
        if (!e.is_err)
          check("a_frame_outs", {4'd0, a_out0, a_out1, a_out2, a_out3}, {4'd0, e.outs});
      end
    end
    if (!reset && (b_fv || b_se)) begin
      ev_t e;
      check("b_fv_se_exclusive", {6'd0, b_fv, b_se} == 8'd3 ? 8'd1 : 8'd0, 8'd0);
      if (qb.size() == 0) begin
        check("b_unexpected_event", {6'd0, b_fv, b_se}, 8'd0);
      end else begin
        e = qb.pop_front();
        check("b_event_kind", {7'd0, b_se}, {7'd0, e.is_err});
        if (!e.is_err)
          check("b_frame_outs", {4'd0, b_out0, b_out1, b_out2, b_out3}, {4'd0, e.outs});
      end
    end
  end

  initial begin
    // Reset state, before any clock edge
    #1;
    check("reset_a_outs", {4'd0, a_out0, a_out1, a_out2, a_out3}, 8'h00);
    check("reset_b_outs", {4'd0, b_out0, b_out1, b_out2, b_out3}, 8'h00);
    check("reset_a_addr", {6'd0, a_addr1, a_addr0}, 8'd0);
    check("reset_a_pulses", {6'd0, a_fv, a_se}, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic frame 1,0,1,1
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    push_frame(4'b1011, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("basic_a_addr", {6'd0, a_addr1, a_addr0}, 8'd0);
    check("basic_b_addr", {6'd0, b_addr1, b_addr0}, 8'd0);

    // Same frame with a 3-cycle enable gap after slot 1; inputs toggle but are ignored
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, i[0]);
      check("gap_a_addr", {6'd0, a_addr1, a_addr0}, 8'd2);
      check("gap_b_addr", {6'd0, b_addr1, b_addr0}, 8'd2);
    end
    step(1'b1, 1'b0, 1'b1);
    push_frame(4'b1011, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);

    // Back-to-back frame 1,0,0,1 with sync at index 0 (normal start)
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    push_frame(4'b1001, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);

    // Misplaced sync at index 2: A resyncs, B drops to HUNT
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    push_err(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    check("err_a_addr", {6'd0, a_addr1, a_addr0}, 8'd1);
    check("err_b_addr", {6'd0, b_addr1, b_addr0}, 8'd0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    push_frame(4'b0110, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("hunt_b_outs_held", {4'd0, b_out0, b_out1, b_out2, b_out3}, 8'h09);
    check("hunt_b_addr", {6'd0, b_addr1, b_addr0}, 8'd0);
    check("resync_a_outs_held", {4'd0, a_out0, a_out1, a_out2, a_out3}, 8'h06);

    // Reset, then data without sync: stays in HUNT
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1);
      check("nosync_a_addr", {6'd0, a_addr1, a_addr0}, 8'd0);
      check("nosync_b_addr", {6'd0, b_addr1, b_addr0}, 8'd0);
    end
    check("nosync_a_outs", {4'd0, a_out0, a_out1, a_out2, a_out3}, 8'h00);
    check("nosync_b_outs", {4'd0, b_out0, b_out1, b_out2, b_out3}, 8'h00);

    // One completed frame, then asynchronous reset at index 2
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    push_frame(4'b1011, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("pre_areset_a_addr", {6'd0, a_addr1, a_addr0}, 8'd2);
    #1;
    reset = 1'b1;
    #1;
    check("areset_a_outs", {4'd0, a_out0, a_out1, a_out2, a_out3}, 8'h00);
    check("areset_b_outs", {4'd0, b_out0, b_out1, b_out2, b_out3}, 8'h00);
    check("areset_a_addr", {6'd0, a_addr1, a_addr0}, 8'd0);
    check("areset_b_addr", {6'd0, b_addr1, b_addr0}, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    // First enabled edge after release with sync is slot 0: frame 1,1,0,1
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    push_frame(4'b1101, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    check("a_queue_drained", qa.size() > 255 ? 8'hff : 8'(qa.size()), 8'd0);
    check("b_queue_drained", qb.size() > 255 ? 8'hff : 8'(qb.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter WIDTH, default 1: bit width of each time slot, of din, and of out0..out3.
REQ-002 Parameter RESYNC_ON_ERR, default 1: 1 realigns on a misplaced sync; 0 drops to HUNT.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  slot strobe; din/sync sampled only on edges where enable=1.
REQ-006 sync  input  1  marks the slot-0 sample of a frame.
REQ-007 din  input  WIDTH  serial TDM data from a 4:1 channel-scanning multiplexer.
REQ-008 out0, out1, out2, out3  output  WIDTH each  registered channel data of last complete frame.
REQ-009 address0, address1  output  1 each  LSB/MSB of next expected slot index.
REQ-010 frame_valid  output  1  one-cycle pulse: out0..out3 just updated.
REQ-011 sync_err  output  1  one-cycle pulse: sync seen at slot index other than 0.

Function
REQ-012 Two states SHALL exist: HUNT (unaligned) and RUN (aligned); slot index is a 2-bit counter {address1,address0}.
REQ-013 Edges with enable=0 SHALL change no state, index, shadow or output; frame_valid and sync_err SHALL be 0 the following cycle.
REQ-014 HUNT: index held at 0; din ignored unless sync=1.
REQ-015 HUNT, enable=1, sync=1: din captured into shadow slot 0, index->1, state->RUN, sync_err stays 0.
REQ-016 RUN, enable=1, sync=0: din captured into shadow[index], index increments modulo 4 (3 wraps to 0).
REQ-017 RUN, enable=1, sync=1, index=0: normal frame start, identical to REQ-016, no error.
REQ-018 RUN, enable=1, sync=1, index!=0: sync_err=1 next cycle; partial frame discarded (no frame_valid, outputs unchanged).
REQ-019 With RESYNC_ON_ERR=1, that same edge SHALL capture din as slot 0 and set index->1, staying in RUN.
REQ-020 With RESYNC_ON_ERR=0, that same edge SHALL capture nothing and set state->HUNT, index->0.
REQ-021 On the edge capturing slot 3 (enable=1, index=3, no error): out0..out2 <= shadow 0..2, out3 <= din, frame_valid=1 for exactly the next cycle.
REQ-022 Latency: out3 reflects the slot-3 din one cycle after it is presented; back-to-back frames yield frame_valid every 4th enabled edge.
REQ-023 Outputs out0..out3 SHALL hold value between frame_valid pulses; a frame spanning enable=0 gaps is still valid.
REQ-024 All outputs SHALL be driven from registers; no combinational path from inputs to outputs.
REQ-025 sync_err and frame_valid SHALL never both be 1 in the same cycle.

Reset
REQ-026 reset=1 SHALL immediately, without clk, force state HUNT, index 0, shadow 0, out0..out3=0, frame_valid=0, sync_err=0.
REQ-027 Reset mid-frame SHALL discard the partial frame; after release the block waits for sync in HUNT.
REQ-028 First enabled edge after reset release with sync=1 SHALL be accepted as slot 0.

Verification
REQ-029 WIDTH=1, enable=1 continuous, sync on slot 0, din sequence 1,0,1,1 -> after 4th edge frame_valid=1 one cycle, out0..3=1,0,1,1, address={0,0}.
REQ-030 Same frame with enable=0 inserted for 3 cycles after slot 1 -> same outputs, frame_valid delayed 3 cycles, address held at 2 during gap.
REQ-031 din 1,1,1,1 without any sync -> stays HUNT, address 0, outputs 0, no frame_valid.
REQ-032 RESYNC_ON_ERR=1: sync, 1,0, then sync at index 2 with din 0 followed by 1,1,0 -> sync_err pulse, no frame_valid for first partial, then out0..3=0,1,1,0.
REQ-033 RESYNC_ON_ERR=0: same misplaced sync -> sync_err pulse, address returns to 0, later data ignored until next sync.
REQ-034 Assert reset asynchronously between clock edges at index 2 after one completed frame (out=1,0,1,1) -> outputs 0 and address 0 before next edge; next sync frame decodes normally.
